neopixel_frame_ctrl: RTL and testbench

NEOPIXEL_FRAME_CTRL -- requirements
Module: neopixel_frame_ctrl

---
 rtl/neopixel_pkg.sv | 11 +
 rtl/neopixel_frame_ctrl_rr_arb2.sv | 30 +++
 rtl/neopixel_frame_ctrl.sv | 93 +++++++++
 tb/tb_neopixel_frame_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared frame geometry and controller state encoding for the neopixel frame path.
package neopixel_pkg;
  localparam int NUM_LEDS = 16;
  localparam int LED_W    = 24;
  localparam int FB_W     = LED_W * NUM_LEDS;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;
endpackage

// File: rtl/neopixel_frame_ctrl_rr_arb2.sv
// Two-port round-robin arbiter: combinational grant, pointer moves only on an accepted grant.
// A zero pointer favours port 0; after serving a port the other port is favoured.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_ptr;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !r_ptr)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (advance) begin
      r_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/neopixel_frame_ctrl.sv
// Double-buffered pixel store: writes land in back, commit swaps to front at the next frame_sync.
// Writes are acked combinationally, one per cycle; acks drop while a swap is pending.
module neopixel_frame_ctrl
  import neopixel_pkg::*;
#(
  parameter int  NUM_LEDS = neopixel_pkg::NUM_LEDS,
  localparam int FB_W     = LED_W * NUM_LEDS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_sync,
  input  logic            req0,
  input  logic            req1,
  input  logic [3:0]      addr0,
  input  logic [3:0]      addr1,
  input  logic [23:0]     rgb0,
  input  logic [23:0]     rgb1,
  output logic            ack0,
  output logic            ack1,
  input  logic            commit,
  output logic [FB_W-1:0] framebuf,
  output logic            pending,
  output logic [7:0]      swap_count,
  output logic            addr_err
);

  state_t            r_state;
  logic [FB_W-1:0]   r_back;
  logic [FB_W-1:0]   r_front;
  logic [7:0]        r_swap_count;
  logic              r_addr_err;

  logic              w_open;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_wr;
  logic [3:0]        w_addr;
  logic [LED_W-1:0]  w_rgb;

  // Requests are masked while pending or in reset so the committed frame cannot tear.
  assign w_open = (r_state == IDLE) && !rst;
  assign w_req  = {req1, req0} & {2{w_open}};
  assign w_wr   = |w_gnt;
  assign w_addr = w_gnt[1] ? addr1 : addr0;
  assign w_rgb  = w_gnt[1] ? rgb1  : rgb0;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_wr),
    .gnt     (w_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_back       <= '0;
      r_front      <= '0;
      r_swap_count <= 8'd0;
      r_addr_err   <= 1'b0;
    end else begin
      if (w_wr) begin
        for (int n = 0; n < NUM_LEDS; n++) begin
          if (w_addr == 4'(n)) r_back[n*LED_W +: LED_W] <= w_rgb;
        end
        if (int'(w_addr) >= NUM_LEDS) r_addr_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          // A frame_sync coinciding with commit is deliberately not a swap.
          if (commit) r_state <= PENDING;
        end
        PENDING: begin
          if (frame_sync) begin
            r_front      <= r_back;
            r_swap_count <= r_swap_count + 8'd1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack0       = w_gnt[0];
  assign ack1       = w_gnt[1];
  assign framebuf   = r_front;
  assign pending    = (r_state == PENDING);
  assign swap_count = r_swap_count;
  assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Directed bench for neopixel_frame_ctrl built for a 15-LED frame, so that address 15
// is a real out-of-range target for the 4-bit address ports.
module tb_neopixel_frame_ctrl;

  localparam int NL = 15;
  localparam int TW = 24 * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_sync, req0, req1, commit;
  logic [3:0]    addr0, addr1;
  logic [23:0]   rgb0, rgb1;
  logic          ack0, ack1, pending, addr_err;
  logic [TW-1:0] framebuf;
  logic [7:0]    swap_count;

  logic [TW-1:0] m_back, m_front;
  int            n_vec = 0;
  int            n_bad = 0;

  neopixel_frame_ctrl #(.NUM_LEDS(NL)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_sync (frame_sync),
    .req0       (req0),
    .req1       (req1),
    .addr0      (addr0),
    .addr1      (addr1),
    .rgb0       (rgb0),
    .rgb1       (rgb1),
    .ack0       (ack0),
    .ack1       (ack1),
    .commit     (commit),
    .framebuf   (framebuf),
    .pending    (pending),
    .swap_count (swap_count),
    .addr_err   (addr_err)
  );

  always #25 clk = ~clk;

  task automatic check_vec(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r0, input logic [3:0] a0, input logic [23:0] g0,
                       input logic r1, input logic [3:0] a1, input logic [23:0] g1,
                       input logic cm, input logic fs);
    @(negedge clk);
    req0 = r0; addr0 = a0; rgb0 = g0;
    req1 = r1; addr1 = a1; rgb1 = g1;
    commit = cm; frame_sync = fs;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int n, input logic [23:0] v);
    m_back[n*24 +: 24] = v;
  endtask

  logic [3:0]  t_a0 [4] = '{4'd1, 4'd2, 4'd4, 4'd11};
  logic [23:0] t_g0 [4] = '{24'h111111, 24'h222222, 24'h444444, 24'hBBBBBB};
  logic [3:0]  t_a1 [4] = '{4'd8, 4'd9, 4'd10, 4'd12};
  logic [23:0] t_g1 [4] = '{24'h888888, 24'h999999, 24'hAAAAAA, 24'hCCCCCC};
  logic        t_w0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    {req0, req1, commit, frame_sync} = '0;
    addr0 = '0; addr1 = '0; rgb0 = '0; rgb1 = '0;
    m_back = '0; m_front = '0;

    // Reset state, with requests asserted during reset
    #60;
    check_vec("rst_framebuf", framebuf, '0);
    check_vec("rst_pending", TW'(pending), TW'(0));
    check_vec("rst_swap_count", TW'(swap_count), TW'(0));
    check_vec("rst_addr_err", TW'(addr_err), TW'(0));
    req0 = 1'b1; req1 = 1'b1; #1;
    check_vec("rst_ack0", TW'(ack0), TW'(0));
    check_vec("rst_ack1", TW'(ack1), TW'(0));

    // First write right after reset release, then commit and swap
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; addr0 = 4'd3; rgb0 = 24'h00FF00; req1 = 1'b0;
    #1;
    check_vec("w3_ack0", TW'(ack0), TW'(1));
    check_vec("w3_ack1", TW'(ack1), TW'(0));
    step(); put(3, 24'h00FF00);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check_vec("w3_front_unchanged", framebuf, '0);
    step();
    check_vec("w3_pending", TW'(pending), TW'(1));
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step(); m_front = m_back;
    check_vec("w3_pixel", TW'(framebuf[95:72]), TW'(24'h00FF00));
    check_vec("w3_framebuf", framebuf, m_front);
    check_vec("w3_swap_count", TW'(swap_count), TW'(1));
    check_vec("w3_pending_low", TW'(pending), TW'(0));

    // Lone port-1 write leaves port 0 favoured for the contention run
    drive(0, 0, 0, 1, 4'd0, 24'hABCDEF, 0, 0);
    check_vec("p1_ack1", TW'(ack1), TW'(1));
    check_vec("p1_ack0", TW'(ack0), TW'(0));
    step(); put(0, 24'hABCDEF);

    for (int i = 0; i < 4; i++) begin
      drive(1, t_a0[i], t_g0[i], 1, t_a1[i], t_g1[i], 0, 0);
      check_vec($sformatf("rr%0d_ack0", i), TW'(ack0), TW'(t_w0[i]));
      check_vec($sformatf("rr%0d_ack1", i), TW'(ack1), TW'(!t_w0[i]));
      step();
      if (t_w0[i]) put(int'(t_a0[i]), t_g0[i]);
      else         put(int'(t_a1[i]), t_g1[i]);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1); step(); m_front = m_back;
    check_vec("rr_framebuf", framebuf, m_front);
    check_vec("rr_swap_count", TW'(swap_count), TW'(2));

    // Commit with frame_sync on the same edge, plus a write folded into the commit
    drive(1, 4'd5, 24'h0F0F0F, 0, 0, 0, 1, 1);
    check_vec("cs_ack0", TW'(ack0), TW'(1));
    step(); put(5, 24'h0F0F0F);
    check_vec("cs_pending", TW'(pending), TW'(1));
    check_vec("cs_no_swap", framebuf, m_front);
    check_vec("cs_swap_count", TW'(swap_count), TW'(2));
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd6, 24'h666666, 1, 4'd7, 24'h777777, (i == 1), 0);
      check_vec($sformatf("pd%0d_ack0", i), TW'(ack0), TW'(0));
      check_vec($sformatf("pd%0d_ack1", i), TW'(ack1), TW'(0));
      step();
      check_vec($sformatf("pd%0d_pending", i), TW'(pending), TW'(1));
    end
    drive(1, 4'd6, 24'h666666, 1, 4'd7, 24'h777777, 0, 1);
    check_vec("sw_ack0", TW'(ack0), TW'(0));
    check_vec("sw_ack1", TW'(ack1), TW'(0));
    step(); m_front = m_back;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_vec("sw_framebuf", framebuf, m_front);
    check_vec("sw_swap_count", TW'(swap_count), TW'(3));
    check_vec("sw_pending_low", TW'(pending), TW'(0));

    // Out-of-range write: acked, discarded, sticky error
    drive(1, 4'd15, 24'h123456, 0, 0, 0, 0, 0);
    check_vec("oor_ack0", TW'(ack0), TW'(1));
    step();
    check_vec("oor_addr_err", TW'(addr_err), TW'(1));
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1); step();
    check_vec("oor_framebuf", framebuf, m_front);
    check_vec("oor_swap_count", TW'(swap_count), TW'(4));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (100) step();
    check_vec("oor_sticky", TW'(addr_err), TW'(1));

    // Reset between commit and frame_sync discards the commit
    drive(1, 4'd2, 24'h0A0B0C, 0, 0, 0, 1, 0); step();
    drive(1, 4'd2, 24'h0A0B0C, 0, 0, 0, 0, 0);
    check_vec("mr_pending", TW'(pending), TW'(1));
    #10 rst = 1'b1;
    #5;
    check_vec("mr_framebuf", framebuf, '0);
    check_vec("mr_pending_low", TW'(pending), TW'(0));
    check_vec("mr_swap_count", TW'(swap_count), TW'(0));
    check_vec("mr_addr_err", TW'(addr_err), TW'(0));
    check_vec("mr_ack0", TW'(ack0), TW'(0));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    m_back = '0; m_front = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 1); step();
    check_vec("mr_fs_framebuf", framebuf, '0);
    check_vec("mr_fs_swap_count", TW'(swap_count), TW'(0));
    check_vec("mr_fs_pending", TW'(pending), TW'(0));

    // 256 commit/swap pairs wrap the counter
    for (int i = 0; i < 256; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 1); step();
      if (i == 254) check_vec("wrap_255", TW'(swap_count), TW'(255));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_vec("wrap_0", TW'(swap_count), TW'(0));
    check_vec("wrap_pending", TW'(pending), TW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
